// File: rtl/ch3_wave_sequencer.sv
// Wave channel (ch3) playback controller: timer, wave table sequencing, length counter,
// DAC gating, volume shift and wave RAM sharing. Define CH3_CPU_SNOOP_EN for the DMG CPU snoop quirk.
module ch3_wave_sequencer #(
    parameter int unsigned START_DELAY = 3,
    parameter int unsigned LEN_BITS    = 9
) (
    input  logic       cery_2mhz,
    input  logic       napu_reset,
    input  logic       dac_en,
    input  logic       len_load,
    input  logic [7:0] len_data,
    input  logic [1:0] vol_code,
    input  logic [10:0] freq,
    input  logic       len_en,
    input  logic       trigger,
    input  logic       len_tick,
    input  logic       cpu_wave_req,
    input  logic [3:0] cpu_wave_addr,
    output logic       cpu_wave_gnt,
    output logic [3:0] wave_addr,
    output logic       wave_rd,
    input  logic [7:0] wave_data,
    output logic       ch_on,
    output logic [3:0] sample
);

    localparam int unsigned TIMER_W = 11;
    localparam int unsigned POS_W   = 5;
    localparam int unsigned SCNT_W  = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [TIMER_W-1:0]  TIMER_MAX  = '1;
    localparam logic [SCNT_W-1:0]   START_LAST = SCNT_W'(START_DELAY - 1);
    localparam logic [LEN_BITS-1:0] LEN_FULL   = LEN_BITS'(256);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [SCNT_W-1:0]    start_cnt;
    logic [TIMER_W-1:0]   timer;
    logic [POS_W-1:0]     pos;
    logic [LEN_BITS-1:0]  len_cnt;
    logic [LEN_BITS-1:0]  len_base;
    logic [LEN_BITS-1:0]  len_after;
    logic [LEN_BITS-1:0]  len_nxt;
    logic                 len_dec;
    logic                 len_expire;
    logic                 ch_on_q;
    logic                 rd_q;
    logic                 lat_q;
    logic                 lat_sel;
    logic [3:0]           nibble;
    logic                 trig_ok;
    logic                 overflow;

    assign trig_ok  = trigger & dac_en;
    assign overflow = (state == ST_RUN) && (timer == TIMER_MAX);

    // Length counter: load beats everything; a trigger reload of an empty counter precedes the tick.
    always_comb begin
        len_base   = len_cnt;
        len_after  = len_cnt;
        len_nxt    = len_cnt;
        len_dec    = 1'b0;
        len_expire = 1'b0;
        if (trig_ok && (len_cnt == '0)) begin
            len_base = LEN_FULL;
        end
        len_dec   = len_tick & len_en & (len_base != '0);
        len_after = len_dec ? (len_base - LEN_BITS'(1)) : len_base;
        if (len_load) begin
            len_nxt = LEN_FULL - LEN_BITS'(len_data);
        end else begin
            len_nxt    = len_after;
            len_expire = len_dec & (len_after == '0);
        end
    end

    // Next-state logic: DAC off or length expiry always forces OFF.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_OFF:   if (trig_ok) state_nxt = ST_START;
            ST_START: if (start_cnt == START_LAST) state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = ST_OFF;
        endcase
        if (trig_ok) begin
            state_nxt = ST_START;
        end
        if (!dac_en || len_expire) begin
            state_nxt = ST_OFF;
        end
    end

    always_ff @(posedge cery_2mhz or negedge napu_reset) begin
        if (!napu_reset) begin
            state <= ST_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    // Timer, position and START delay.
    always_ff @(posedge cery_2mhz or negedge napu_reset) begin
        if (!napu_reset) begin
            start_cnt <= '0;
            timer     <= '0;
            pos       <= '0;
        end else begin
            if (trig_ok || (state != ST_START)) begin
                start_cnt <= '0;
            end else begin
                start_cnt <= start_cnt + SCNT_W'(1);
            end
            if (trig_ok) begin
                timer <= freq;
                pos   <= '0;
            end else if (state == ST_RUN) begin
                if (overflow) begin
                    timer <= freq;
                    pos   <= pos + POS_W'(1);
                end else begin
                    timer <= timer + TIMER_W'(1);
                end
            end
        end
    end

    // Fetch pipeline: strobe after overflow, RAM data the cycle after, nibble latched next.
    always_ff @(posedge cery_2mhz or negedge napu_reset) begin
        if (!napu_reset) begin
            rd_q    <= 1'b0;
            lat_q   <= 1'b0;
            lat_sel <= 1'b0;
            nibble  <= '0;
        end else begin
            rd_q    <= overflow & dac_en & ~trig_ok;
            lat_q   <= rd_q & dac_en;
            lat_sel <= pos[0];
            if (!dac_en) begin
                nibble <= '0;
            end else if (lat_q) begin
                nibble <= lat_sel ? wave_data[3:0] : wave_data[7:4];
            end
        end
    end

    always_ff @(posedge cery_2mhz or negedge napu_reset) begin
        if (!napu_reset) begin
            len_cnt <= '0;
            ch_on_q <= 1'b0;
        end else begin
            len_cnt <= len_nxt;
            if (!dac_en || len_expire) begin
                ch_on_q <= 1'b0;
            end else if (trig_ok) begin
                ch_on_q <= 1'b1;
            end
        end
    end

    assign wave_rd = rd_q;
    assign ch_on   = ch_on_q & dac_en;

    // Volume shift on the held nibble, so vol_code changes show up immediately.
    always_comb begin
        sample = '0;
        case (vol_code)
            2'b00:   sample = '0;
            2'b01:   sample = nibble;
            2'b10:   sample = nibble >> 1;
            2'b11:   sample = nibble >> 2;
            default: sample = '0;
        endcase
    end

`ifdef CH3_CPU_SNOOP_EN
    // DMG quirk: while playing, the CPU only sees the byte the channel is fetching.
    always_comb begin
        cpu_wave_gnt = 1'b0;
        wave_addr    = pos[4:1];
        if (ch_on) begin
            cpu_wave_gnt = cpu_wave_req & rd_q;
        end else begin
            cpu_wave_gnt = cpu_wave_req & ~rd_q;
            if (cpu_wave_gnt) begin
                wave_addr = cpu_wave_addr;
            end
        end
    end
`else
    // Channel fetch has priority; a denied CPU request is served on the following free cycle.
    always_comb begin
        cpu_wave_gnt = cpu_wave_req & ~rd_q;
        wave_addr    = pos[4:1];
        if (cpu_wave_gnt) begin
            wave_addr = cpu_wave_addr;
        end
    end
`endif

endmodule

// File: tb/tb_ch3_wave_sequencer.sv
// Scoreboard bench for ch3_wave_sequencer: directed stimulus pushes expected fetches, a monitor checks them.
module tb_ch3_wave_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dac_en = 1'b0;
    logic        len_load = 1'b0;
    logic [7:0]  len_data = '0;
    logic [1:0]  vol_code = '0;
    logic [10:0] freq = '0;
    logic        len_en = 1'b0;
    logic        trigger = 1'b0;
    logic        len_tick = 1'b0;
    logic        cpu_wave_req = 1'b0;
    logic [3:0]  cpu_wave_addr = '0;
    logic        cpu_wave_gnt;
    logic [3:0]  wave_addr;
    logic        wave_rd;
    logic [7:0]  wave_data = '0;
    logic        ch_on;
    logic [3:0]  sample;

    logic [7:0]  ram [16];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;

    typedef struct {
        logic [3:0] addr;
        logic [3:0] smp;
        int         gap;
    } exp_t;
    exp_t exp_q[$];

    logic       p1_v = 1'b0;
    logic       p2_v = 1'b0;
    logic [3:0] p1_s = '0;
    logic [3:0] p2_s = '0;
    int         last_rd_cyc = 0;

    ch3_wave_sequencer dut (
        .cery_2mhz     (clk),
        .napu_reset    (rst_n),
        .dac_en        (dac_en),
        .len_load      (len_load),
        .len_data      (len_data),
        .vol_code      (vol_code),
        .freq          (freq),
        .len_en        (len_en),
        .trigger       (trigger),
        .len_tick      (len_tick),
        .cpu_wave_req  (cpu_wave_req),
        .cpu_wave_addr (cpu_wave_addr),
        .cpu_wave_gnt  (cpu_wave_gnt),
        .wave_addr     (wave_addr),
        .wave_rd       (wave_rd),
        .wave_data     (wave_data),
        .ch_on         (ch_on),
        .sample        (sample)
    );

    always #5 clk = ~clk;

    // Wave RAM model: synchronous read, data valid the cycle after wave_rd.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wave_rd) wave_data <= ram[wave_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation per channel fetch, checks address, cadence and sample two cycles later.
    always @(negedge clk) begin
        exp_t e;
        if (p2_v) check("fetch_sample", 32'(sample), 32'(p2_s));
        p2_v = p1_v;
        p2_s = p1_s;
        p1_v = 1'b0;
        if (wave_rd && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("fetch_addr", 32'(wave_addr), 32'(e.addr));
            if (e.gap != 0) check("fetch_gap", 32'(cyc - last_rd_cyc), 32'(e.gap));
            p1_v = 1'b1;
            p1_s = e.smp;
        end
        if (wave_rd) last_rd_cyc = cyc;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ram(input logic [7:0] v);
        for (int i = 0; i < 16; i++) ram[i] = v;
    endtask

    function automatic logic [3:0] vol_exp(input int v);
        case (v)
            0: return 4'h0;
            1: return 4'hF;
            2: return 4'h7;
            default: return 4'h3;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int fall_at;
        int rd_cnt;
        exp_t e;
        fill_ram(8'hA5);

        // Reset values
        #12;
        check("rst_ch_on", 32'(ch_on), 0);
        check("rst_sample", 32'(sample), 0);
        check("rst_wave_rd", 32'(wave_rd), 0);
        check("rst_gnt", 32'(cpu_wave_gnt), 0);
        check("rst_wave_addr", 32'(wave_addr), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Playback of A5 bytes at freq 2046: fetch every 2 cycles, samples 5, A, 5, ...
        dac_en = 1'b1; vol_code = 2'b01; freq = 11'd2046; len_en = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            e.addr = 4'(k >> 1);
            e.smp  = (k % 2 == 1) ? 4'h5 : 4'hA;
            e.gap  = (k == 1) ? 0 : 2;
            exp_q.push_back(e);
        end
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("trig_ch_on", 32'(ch_on), 1);
        n = 0;
        while (!wave_rd && n < 20) begin tick(); n++; end
        check("first_fetch_latency", 32'(n), 5);
        n = 0;
        while ((exp_q.size() != 0 || p1_v || p2_v) && n < 40) begin tick(); n++; end
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        // Volume sweep on nibble F
        fill_ram(8'hFF);
        repeat (8) tick();
        for (int v = 0; v < 4; v++) begin
            vol_code = 2'(v);
            #1;
            check("vol_sweep", 32'(sample), 32'(vol_exp(v)));
        end
        vol_code = 2'b01;

        // CPU request during a fetch cycle
        n = 0;
        while (!wave_rd && n < 10) begin tick(); n++; end
        check("saw_fetch_for_cpu", 32'(wave_rd), 1);
        cpu_wave_req = 1'b1; cpu_wave_addr = 4'h9;
        #1;
        check("cpu_gnt_denied", 32'(cpu_wave_gnt), 0);
        tick();
        check("cpu_free_cycle", 32'(wave_rd), 0);
        check("cpu_gnt_next", 32'(cpu_wave_gnt), 1);
        check("cpu_wave_addr", 32'(wave_addr), 32'h9);
        cpu_wave_req = 1'b0;

        // DAC off in RUN, then trigger with DAC off
        dac_en = 1'b0;
        #1;
        check("dac_off_ch_on", 32'(ch_on), 0);
        tick();
        check("dac_off_sample", 32'(sample), 0);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        check("trig_dac_off", 32'(ch_on), 0);

        // Length: len_data FE -> off on 2nd tick
        dac_en = 1'b1; len_en = 1'b1;
        len_data = 8'hFE; len_load = 1'b1;
        tick();
        len_load = 1'b0; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("len_fe_on", 32'(ch_on), 1);
        len_tick = 1'b1; tick(); len_tick = 1'b0;
        check("len_fe_tick1", 32'(ch_on), 1);
        len_tick = 1'b1; tick(); len_tick = 1'b0;
        check("len_fe_tick2", 32'(ch_on), 0);

        // Length: len_data 0 -> 256 ticks
        len_data = 8'h00; len_load = 1'b1;
        tick();
        len_load = 1'b0; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        fall_at = 0;
        for (int i = 1; i <= 300 && fall_at == 0; i++) begin
            len_tick = 1'b1; tick(); len_tick = 1'b0;
            if (!ch_on) fall_at = i;
        end
        check("len_00_ticks", 32'(fall_at), 256);

        // Trigger and tick together with empty counter: 256 -> 255
        trigger = 1'b1; len_tick = 1'b1;
        tick();
        trigger = 1'b0; len_tick = 1'b0;
        check("trig_tick_on", 32'(ch_on), 1);
        fall_at = 0;
        for (int i = 1; i <= 300 && fall_at == 0; i++) begin
            len_tick = 1'b1; tick(); len_tick = 1'b0;
            if (!ch_on) fall_at = i;
        end
        check("trig_tick_ticks", 32'(fall_at), 255);

        // Reset mid-playback
        len_en = 1'b0;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        repeat (12) tick();
        check("pre_reset_sample", 32'(sample), 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ch_on", 32'(ch_on), 0);
        check("mid_rst_sample", 32'(sample), 0);
        check("mid_rst_wave_rd", 32'(wave_rd), 0);
        check("mid_rst_gnt", 32'(cpu_wave_gnt), 0);
        check("mid_rst_wave_addr", 32'(wave_addr), 0);
        tick();
        rst_n = 1'b1;
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wave_rd) rd_cnt++;
        end
        check("post_rst_no_fetch", 32'(rd_cnt), 0);
        check("post_rst_ch_on", 32'(ch_on), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
